// File: rtl/dm_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter and the data memory.
// Store/load encodings, owner state, misalignment predicate.
package dm_arbiter_pkg;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DMA_OWN = 2'd2
  } arb_state_e;

  // A store wins over a load, so only the store's alignment matters then.
  function automatic logic misaligned(
    input logic [1:0] wr,
    input logic [2:0] rd,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    if (wr == ST_SH) begin
      m = a[0];
    end else if (wr == ST_SW) begin
      m = |a;
    end else if (wr == ST_NONE) begin
      if (rd == LD_LH || rd == LD_LHU) begin
        m = a[0];
      end else if (rd == LD_LW) begin
        m = |a;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_arb_req_decode.sv
// Per-requester decode: effective request, misalignment, sanitized codes.
// Misaligned accesses keep their grant but carry no memory operation.
module dm_arb_req_decode
  import dm_arbiter_pkg::*;
(
  input  logic       req,
  input  logic [1:0] addr_lo,
  input  logic [1:0] mem_write,
  input  logic [2:0] mem_read,
  output logic       eff,
  output logic       mis,
  output logic [1:0] wr_code,
  output logic [2:0] rd_code
);

  always_comb begin
    eff = req && (mem_write != ST_NONE || mem_read != LD_NONE);
    mis = misaligned(mem_write, mem_read, addr_lo);
    wr_code = mis ? ST_NONE : mem_write;
    rd_code = (mis || mem_write != ST_NONE) ? LD_NONE : mem_read;
  end

endmodule

// File: rtl/dm_arbiter.sv
// CPU/DMA arbiter and sequencer in front of the single-port data memory.
// Optional perf counters are built when DM_ARB_PERF_EN is defined.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int BURST_MAX  = 16,
  parameter int CNT_W      = 5
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CpuReq,
  input  logic [31:0] CpuAddr,
  input  logic [31:0] CpuWData,
  input  logic [1:0]  CpuMemWrite,
  input  logic [2:0]  CpuMemRead,
  output logic        CpuStall,
  output logic [31:0] CpuRData,
  output logic        CpuRValid,
  input  logic        DmaReq,
  input  logic [31:0] DmaAddr,
  input  logic [31:0] DmaWData,
  input  logic [1:0]  DmaMemWrite,
  input  logic [2:0]  DmaMemRead,
  input  logic        DmaLast,
  output logic        DmaGnt,
  output logic [31:0] DmaRData,
  output logic        DmaRValid,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [1:0]  MemWriteOut,
  output logic [2:0]  MemReadOut,
  input  logic [31:0] MemRData,
  output logic        MisalignErr,
  output logic [31:0] PerfCpuStall,
  output logic [31:0] PerfDmaBeats
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic       cpu_eff, cpu_mis, dma_eff, dma_mis;
  logic [1:0] cpu_wr, dma_wr;
  logic [2:0] cpu_rd, dma_rd;
  logic       cpu_gnt, dma_gnt, burst_lock;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             last_q, last_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             dma_rvalid_q, dma_rvalid_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic [31:0]      dma_rdata_q, dma_rdata_d;
  logic             mis_q, mis_d;

  dm_arb_req_decode u_cpu_dec (
    .req       (CpuReq),
    .addr_lo   (CpuAddr[1:0]),
    .mem_write (CpuMemWrite),
    .mem_read  (CpuMemRead),
    .eff       (cpu_eff),
    .mis       (cpu_mis),
    .wr_code   (cpu_wr),
    .rd_code   (cpu_rd)
  );

  dm_arb_req_decode u_dma_dec (
    .req       (DmaReq),
    .addr_lo   (DmaAddr[1:0]),
    .mem_write (DmaMemWrite),
    .mem_read  (DmaMemRead),
    .eff       (dma_eff),
    .mis       (dma_mis),
    .wr_code   (dma_wr),
    .rd_code   (dma_rd)
  );

  always_comb begin
    burst_lock = state_q == DMA_OWN && dma_eff &&
                 burst_q < BURST_LIM && !last_q;
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (Reset) begin
      if (burst_lock) begin
        dma_gnt = 1'b1;
      end else if (dma_eff && starve_q == STARVE_LIM) begin
        dma_gnt = 1'b1;
      end else if (cpu_eff) begin
        cpu_gnt = 1'b1;
      end else if (dma_eff) begin
        dma_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    MemAddr     = '0;
    MemWData    = '0;
    MemWriteOut = ST_NONE;
    MemReadOut  = LD_NONE;
    if (cpu_gnt) begin
      MemAddr     = CpuAddr;
      MemWData    = CpuWData;
      MemWriteOut = cpu_wr;
      MemReadOut  = cpu_rd;
    end else if (dma_gnt) begin
      MemAddr     = DmaAddr;
      MemWData    = DmaWData;
      MemWriteOut = dma_wr;
      MemReadOut  = dma_rd;
    end
  end

  always_comb begin
    state_d = cpu_gnt ? CPU_OWN : (dma_gnt ? DMA_OWN : IDLE);
    last_d  = dma_gnt ? DmaLast : last_q;

    starve_d = starve_q;
    if (dma_gnt) begin
      starve_d = '0;
    end else if (dma_eff && starve_q != STARVE_LIM) begin
      starve_d = starve_q + CNT_ONE;
    end

    burst_d = '0;
    if (dma_gnt) begin
      burst_d = (burst_q == BURST_LIM) ? burst_q : burst_q + CNT_ONE;
    end

    cpu_rvalid_d = cpu_gnt && cpu_rd != LD_NONE;
    dma_rvalid_d = dma_gnt && dma_rd != LD_NONE;
    cpu_rdata_d  = cpu_rvalid_d ? MemRData : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid_d ? MemRData : dma_rdata_q;
    mis_d = (cpu_gnt && cpu_mis) || (dma_gnt && dma_mis);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      burst_q      <= '0;
      last_q       <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      burst_q      <= burst_d;
      last_q       <= last_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      mis_q        <= mis_d;
    end
  end

  assign CpuStall    = cpu_eff && !cpu_gnt;
  assign DmaGnt      = dma_gnt;
  assign CpuRValid   = cpu_rvalid_q;
  assign CpuRData    = cpu_rdata_q;
  assign DmaRValid   = dma_rvalid_q;
  assign DmaRData    = dma_rdata_q;
  assign MisalignErr = mis_q;

`ifdef DM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_beats_q, perf_beats_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'b0, CpuStall};
    perf_beats_d = perf_beats_q + {31'b0, dma_gnt};
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      perf_stall_q <= '0;
      perf_beats_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_beats_q <= perf_beats_d;
    end
  end

  assign PerfCpuStall = perf_stall_q;
  assign PerfDmaBeats = perf_beats_q;
`else
  assign PerfCpuStall = '0;
  assign PerfDmaBeats = '0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed scenarios then random traffic.
// Expectations come from a cycle-level model of the arbitration rules.
module tb_dm_arbiter;

  localparam int STARVE_MAX = 8;
  localparam int BURST_MAX  = 16;
`ifdef DM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic        CpuReq, DmaReq, DmaLast;
  logic [31:0] CpuAddr, CpuWData, DmaAddr, DmaWData;
  logic [1:0]  CpuMemWrite, DmaMemWrite;
  logic [2:0]  CpuMemRead, DmaMemRead;
  logic        CpuStall, CpuRValid, DmaGnt, DmaRValid, MisalignErr;
  logic [31:0] CpuRData, DmaRData, MemAddr, MemWData, MemRData;
  logic [1:0]  MemWriteOut;
  logic [2:0]  MemReadOut;
  logic [31:0] PerfCpuStall, PerfDmaBeats;

  dm_arbiter #(.STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX), .CNT_W(5)) dut (
    .Clock(Clock), .Reset(Reset),
    .CpuReq(CpuReq), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuMemWrite(CpuMemWrite), .CpuMemRead(CpuMemRead),
    .CpuStall(CpuStall), .CpuRData(CpuRData), .CpuRValid(CpuRValid),
    .DmaReq(DmaReq), .DmaAddr(DmaAddr), .DmaWData(DmaWData),
    .DmaMemWrite(DmaMemWrite), .DmaMemRead(DmaMemRead), .DmaLast(DmaLast),
    .DmaGnt(DmaGnt), .DmaRData(DmaRData), .DmaRValid(DmaRValid),
    .MemAddr(MemAddr), .MemWData(MemWData),
    .MemWriteOut(MemWriteOut), .MemReadOut(MemReadOut),
    .MemRData(MemRData), .MisalignErr(MisalignErr),
    .PerfCpuStall(PerfCpuStall), .PerfDmaBeats(PerfDmaBeats)
  );

  initial Clock = 1'b1;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic rst_n; logic creq; logic [1:0] cw; logic [2:0] cr;
    logic [31:0] ca; logic [31:0] cd;
    logic dreq; logic [1:0] dw; logic [2:0] dr;
    logic [31:0] da; logic [31:0] dd; logic dlast;
  } stim_t;

  typedef struct {
    int cyc; logic stall; logic gnt;
    logic [31:0] addr; logic [31:0] wdata;
    logic [1:0] wr; logic [2:0] rd;
    logic [31:0] pstall; logic [31:0] pbeats;
  } comb_t;

  typedef struct {
    int cyc; logic cv; logic [31:0] cd;
    logic dv; logic [31:0] dd; logic mis;
  } reg_t;

  comb_t cq[$];
  reg_t  rq[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Memory seen by the DUT and the model's own copy.
  logic [31:0] dmem [64];
  logic [31:0] rmem [64];
  assign MemRData = dmem[MemAddr[7:2]];

  function automatic logic [31:0] merge(logic [31:0] old, logic [1:0] a,
                                        logic [31:0] d, logic [1:0] w);
    logic [31:0] n;
    n = old;
    case (w)
      2'b01: n[int'(a)*8 +: 8] = d[7:0];
      2'b10: n[int'(a[1])*16 +: 16] = d[15:0];
      2'b11: n = d;
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge Clock)
    if (MemWriteOut != 2'b00)
      dmem[MemAddr[7:2]] <= merge(dmem[MemAddr[7:2]], MemAddr[1:0], MemWData, MemWriteOut);

  function automatic bit mis_of(logic [1:0] w, logic [2:0] r, logic [31:0] a);
    if (w == 2'b10) return a[0];
    if (w == 2'b11) return a[1:0] != 2'b00;
    if (w != 2'b00) return 1'b0;
    if (r == 3'b011 || r == 3'b100) return a[0];
    if (r == 3'b101) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic stim_t mk(logic rst_n, logic creq, logic [1:0] cw,
      logic [2:0] cr, logic [31:0] ca, logic [31:0] cd, logic dreq,
      logic [1:0] dw, logic [2:0] dr, logic [31:0] da, logic [31:0] dd,
      logic dlast);
    stim_t s;
    s.rst_n = rst_n; s.creq = creq; s.cw = cw; s.cr = cr; s.ca = ca; s.cd = cd;
    s.dreq = dreq; s.dw = dw; s.dr = dr; s.da = da; s.dd = dd; s.dlast = dlast;
    return s;
  endfunction

  // Model state: owner 0 none, 1 cpu, 2 dma.
  int m_owner = 0, m_starve = 0, m_burst = 0;
  bit m_last = 0;
  logic [31:0] m_cd = 0, m_dd = 0, m_pstall = 0, m_pbeats = 0;

  task automatic tick(input stim_t s, output int g);
    bit ce, de, mis;
    logic [1:0] w; logic [2:0] r; logic [31:0] a, d;
    comb_t ec; reg_t er;
    @(negedge Clock);
    cyc++;
    Reset = s.rst_n;
    CpuReq = s.creq; CpuMemWrite = s.cw; CpuMemRead = s.cr;
    CpuAddr = s.ca; CpuWData = s.cd;
    DmaReq = s.dreq; DmaMemWrite = s.dw; DmaMemRead = s.dr;
    DmaAddr = s.da; DmaWData = s.dd; DmaLast = s.dlast;
    ce = s.creq && (s.cw != 0 || s.cr != 0);
    de = s.dreq && (s.dw != 0 || s.dr != 0);
    g = 0;
    if (s.rst_n) begin
      if (m_owner == 2 && de && m_burst < BURST_MAX && !m_last) g = 2;
      else if (de && m_starve == STARVE_MAX) g = 2;
      else if (ce) g = 1;
      else if (de) g = 2;
    end
    w = 0; r = 0; a = 0; d = 0;
    if (g == 1) begin w = s.cw; r = s.cr; a = s.ca; d = s.cd; end
    if (g == 2) begin w = s.dw; r = s.dr; a = s.da; d = s.dd; end
    if (w != 0) r = 0;
    mis = mis_of(w, r, a);
    if (mis) begin w = 0; r = 0; end
    ec.cyc = cyc; ec.stall = ce && g != 1; ec.gnt = g == 2;
    ec.addr = a; ec.wdata = d; ec.wr = w; ec.rd = r;
    ec.pstall = PERF ? m_pstall : 32'd0;
    ec.pbeats = PERF ? m_pbeats : 32'd0;
    cq.push_back(ec);
    er.cyc = cyc;
    if (!s.rst_n) begin
      m_owner = 0; m_starve = 0; m_burst = 0; m_last = 0;
      m_cd = 0; m_dd = 0; m_pstall = 0; m_pbeats = 0;
      er.cv = 0; er.dv = 0; er.mis = 0;
    end else begin
      er.cv = g == 1 && r != 0;
      er.dv = g == 2 && r != 0;
      if (er.cv) m_cd = rmem[a[7:2]];
      if (er.dv) m_dd = rmem[a[7:2]];
      er.mis = mis;
      if (w != 0) rmem[a[7:2]] = merge(rmem[a[7:2]], a[1:0], d, w);
      m_pstall += (ce && g != 1) ? 1 : 0;
      m_pbeats += (g == 2) ? 1 : 0;
      if (g == 2) begin
        m_starve = 0;
        m_burst = (m_burst < BURST_MAX) ? m_burst + 1 : m_burst;
        m_last = s.dlast;
      end else begin
        m_burst = 0;
        if (de && m_starve < STARVE_MAX) m_starve++;
      end
      m_owner = g;
    end
    er.cd = m_cd; er.dd = m_dd;
    rq.push_back(er);
  endtask

  task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc %0d got %h want %h", nm, c, act, exp);
    end
  endtask

  // Combinational outputs, sampled late in the low phase.
  initial forever begin
    comb_t e;
    @(negedge Clock);
    #4;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("cpu_stall", e.cyc, {31'b0, CpuStall}, {31'b0, e.stall});
      chk("dma_gnt", e.cyc, {31'b0, DmaGnt}, {31'b0, e.gnt});
      chk("mem_addr", e.cyc, MemAddr, e.addr);
      chk("mem_wdata", e.cyc, MemWData, e.wdata);
      chk("mem_wr", e.cyc, {30'b0, MemWriteOut}, {30'b0, e.wr});
      chk("mem_rd", e.cyc, {29'b0, MemReadOut}, {29'b0, e.rd});
      chk("perf_stall", e.cyc, PerfCpuStall, e.pstall);
      chk("perf_beats", e.cyc, PerfDmaBeats, e.pbeats);
    end
  end

  // Registered outputs, sampled just after the edge.
  initial forever begin
    reg_t e;
    @(posedge Clock);
    #1;
    if (rq.size() > 0) begin
      e = rq.pop_front();
      chk("cpu_rvalid", e.cyc, {31'b0, CpuRValid}, {31'b0, e.cv});
      chk("cpu_rdata", e.cyc, CpuRData, e.cd);
      chk("dma_rvalid", e.cyc, {31'b0, DmaRValid}, {31'b0, e.dv});
      chk("dma_rdata", e.cyc, DmaRData, e.dd);
      chk("misalign", e.cyc, {31'b0, MisalignErr}, {31'b0, e.mis});
    end
  end

  stim_t idle_s;

  initial begin
    int g, beats, n;
    bit cdone;
    stim_t s;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'h5A00_0000 ^ (i * 32'h0101_0101);
      rmem[i] = dmem[i];
    end
    idle_s = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Reset = 0; CpuReq = 0; DmaReq = 0; DmaLast = 0;
    CpuAddr = 0; CpuWData = 0; CpuMemWrite = 0; CpuMemRead = 0;
    DmaAddr = 0; DmaWData = 0; DmaMemWrite = 0; DmaMemRead = 0;
    repeat (2) @(posedge Clock);
    tick(mk(0, 1, 3, 0, 32'h10, 32'h1, 0, 0, 0, 0, 0, 0), g);
    tick(idle_s, g);

    // CPU store then load of the same word.
    tick(mk(1, 1, 3, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0), g);
    tick(mk(1, 1, 0, 5, 32'h10, 0, 0, 0, 0, 0, 0, 0), g);
    tick(idle_s, g);

    // Continuous contention: DMA forced through after STARVE_MAX denials.
    for (int i = 0; i < 12; i++)
      tick(mk(1, 1, 3, 0, 32'h4 * i, 32'h100 + i,
              1, 0, 5, 32'h40, 0, 1), g);
    tick(idle_s, g);

    // 20-beat DMA burst, CPU asks from beat 3 until served.
    beats = 0; cdone = 0; n = 0;
    while (beats < 20 && n < 60) begin
      s = mk(1, n >= 2 && !cdone, 0, 5, 32'h10, 0,
             1, 3, 0, 32'h80 + 4 * (beats % 16), 32'hB000 + beats, beats == 19);
      tick(s, g);
      if (g == 2) beats++;
      if (g == 1) cdone = 1;
      n++;
    end
    chk("burst_beats", n, beats, 20);
    tick(idle_s, g);

    // Misaligned halfword load.
    tick(mk(1, 1, 0, 3, 32'h21, 0, 0, 0, 0, 0, 0, 0), g);
    tick(idle_s, g);

    // Reset during beat 5 of a burst; CPU must win straight after.
    for (int i = 0; i < 4; i++)
      tick(mk(1, 0, 0, 0, 0, 0, 1, 0, 5, 32'hC0 + 4 * i, 0, 0), g);
    tick(mk(0, 1, 0, 5, 32'h10, 0, 1, 0, 5, 32'hD0, 0, 0), g);
    for (int i = 0; i < 3; i++)
      tick(mk(1, 1, 0, 5, 32'h10, 0, 1, 0, 5, 32'hD0, 0, 0), g);
    tick(idle_s, g);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      s.rst_n = $urandom_range(0, 99) != 0;
      s.creq  = $urandom_range(0, 9) < 6;
      s.cw    = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
      s.cr    = 3'($urandom_range(0, 5));
      s.ca    = $urandom_range(0, 255);
      s.cd    = $urandom;
      s.dreq  = $urandom_range(0, 9) < 6;
      s.dw    = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
      s.dr    = 3'($urandom_range(0, 5));
      s.da    = $urandom_range(0, 255);
      s.dd    = $urandom;
      s.dlast = $urandom_range(0, 9) < 2;
      tick(s, g);
    end
    tick(idle_s, g);
    repeat (3) @(negedge Clock);
    #6;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Requester 0 is the pipeline MEM stage (CPU). Requester 1 is the DMA/loader port, used for program load, debug and bulk copy.
- Grants at most one access per cycle to the memory port, stalls the loser, and returns registered read data to the winner.
- Uses CPU-priority arbitration with a DMA starvation guard and a bounded DMA burst.

Parameters:
- STARVE_MAX, 8: consecutive denied DMA cycles after which DMA is force-granted one access.
- BURST_MAX, 16: maximum consecutive DMA grants before a pending CPU request must be served.
- CNT_W, 5: width of the starvation and burst counters; must satisfy 2^CNT_W > max(STARVE_MAX, BURST_MAX).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- CpuReq  in  1  CPU access request.
- CpuAddr  in  32  byte address.
- CpuWData  in  32  store data.
- CpuMemWrite  in  2  store code: 00 none, 01 sb, 10 sh, 11 sw.
- CpuMemRead  in  3  load code: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw.
- CpuStall  out  1  request pending, not granted this cycle.
- CpuRData  out  32  registered load data.
- CpuRValid  out  1  CpuRData valid (one-cycle pulse).
- DmaReq, DmaAddr, DmaWData, DmaMemWrite, DmaMemRead  in  1/32/32/2/3  same meaning as the CPU inputs.
- DmaLast  in  1  final beat of the DMA burst.
- DmaGnt  out  1  DMA access accepted this cycle.
- DmaRData  out  32  registered load data.
- DmaRValid  out  1  DmaRData valid (one-cycle pulse).
- MemAddr, MemWData  out  32  to data memory.
- MemWriteOut  out  2  store code to memory.
- MemReadOut  out  3  load code to memory.
- MemRData  in  32  combinational memory read data.
- MisalignErr  out  1  registered pulse: misaligned access dropped.

Behaviour:
- Effective request: Req=1 and (MemWrite!=0 or MemRead!=0). Req with both codes zero is ignored: no grant, no stall.
- Both codes nonzero: write is performed, read code forced to 000, no RValid.
- Misaligned access (sh/lh/lhu with Addr[0]=1; sw/lw with Addr[1:0]!=0):
  - Granted and consumed, but MemWriteOut=00 and MemReadOut=000.
  - MisalignErr pulses next cycle; no RValid.
- FSM, registered: IDLE, CPU_OWN, DMA_OWN. State equals the owner of the previous cycle's grant; IDLE if there was no grant.
- Grant decision (combinational from state, counters and requests), priority order:
  1. DMA_OWN, DMA request, BurstCnt<BURST_MAX, last granted DMA beat did not have DmaLast=1 -> DMA (burst lock).
  2. DMA request and StarveCnt==STARVE_MAX -> DMA.
  3. CPU request -> CPU.
  4. DMA request -> DMA.
  5. Otherwise no grant.
- Burst end: a DMA grant with DmaLast=1 ends the burst; next cycle re-arbitrates with CPU first.
- BurstCnt at BURST_MAX: lock released. If CPU pending, CPU wins the next cycle even if DMA is still requesting.
- Counters:
  - StarveCnt increments on effective DMA request without DmaGnt, saturating at STARVE_MAX. Cleared on DmaGnt.
  - BurstCnt increments on each DMA grant, saturating. Cleared on any cycle without a DMA grant.
- Memory mux is combinational: Mem* = granted requester's signals. With no grant, MemAddr=0, MemWData=0, MemWriteOut=00, MemReadOut=000. Store commit timing is owned by the memory.
- Outputs:
  - CpuStall = effective CpuReq and not CPU-granted, combinational, same cycle.
  - DmaGnt = DMA granted, same cycle.
- Read return latency is 1: on a granted read, the owner's RData<=MemRData and RValid<=1 at the next edge. RValid is 0 otherwise; RData holds its last value.
- Reset low at an edge:
  - State=IDLE, counters=0, RValid=0, RData=0, MisalignErr=0.
  - While Reset is low, no grants: Mem* idle values, DmaGnt=0, CpuStall=effective CpuReq.
- Reset mid-burst abandons the burst; no partial retry.

Optional Feature:
- Macro DM_ARB_PERF_EN.
- Defined: adds outputs PerfCpuStall[31:0] and PerfDmaBeats[31:0].
  - PerfCpuStall counts cycles with CpuStall=1.
  - PerfDmaBeats counts DmaGnt cycles.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports present, tied to 0, no counter logic.

Decomposition:
- Shared package holds:
  - Store codes SB/SH/SW and load codes LB/LBU/LH/LHU/LW.
  - FSM state typedef (IDLE/CPU_OWN/DMA_OWN).
  - Misalignment predicate function, shared with the data memory.
- One natural sub-module: dm_arb_req_decode, instantiated per requester. Produces effective-request, misaligned and sanitized codes.

Test Plan:
- CPU only:
  - CpuReq, sw, addr 0x10, data 0xDEADBEEF -> no stall, MemWriteOut=11.
  - Then lw @0x10 -> CpuRValid next cycle, CpuRData=0xDEADBEEF.
- Contention: CPU and DMA request continuously, STARVE_MAX=8 -> DMA denied 8 cycles, granted on the 9th; CpuStall=1 exactly that cycle.
- DMA burst of 20 beats, DmaLast on beat 20, CPU requesting from beat 3 -> DMA holds 16 beats, CPU granted cycle 17, DMA resumes.
- Misaligned: CPU lh @0x21 -> MemReadOut=000, MisalignErr pulse next cycle, no CpuRValid, no stall.
- Reset low asserted during beat 5 of a DMA burst -> next cycle state IDLE, DmaGnt=0, counters 0. After Reset high, a CPU request is granted first.
- With DM_ARB_PERF_EN: 8-cycle starvation scenario -> PerfCpuStall=1, PerfDmaBeats=1.
